// File: rtl/axi_inter_rd_arb.sv
// N-master to 1-slave AXI4 read arbiter: round-robin AR grant, in-order R return routing.
// Optional AXI_RD_ARB_ORPHAN_DRAIN_EN: sink and count R beats arriving with no outstanding burst.
module axi_inter_rd_arb #(
    parameter int MST_WIDTH  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int OST_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [2**MST_WIDTH-1:0] m_arvalid,
    output logic [2**MST_WIDTH-1:0] m_arready,
    input  logic [ADDR_WIDTH-1:0]   m_araddr [2**MST_WIDTH],
    input  logic [ID_WIDTH-1:0]     m_arid   [2**MST_WIDTH],
    input  logic [7:0]              m_arlen  [2**MST_WIDTH],
    output logic                    s_arvalid,
    input  logic                    s_arready,
    output logic [ADDR_WIDTH-1:0]   s_araddr,
    output logic [ID_WIDTH-1:0]     s_arid,
    output logic [7:0]              s_arlen,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic [ID_WIDTH-1:0]     s_rid,
    input  logic [1:0]              s_rresp,
    input  logic                    s_rlast,
    output logic [2**MST_WIDTH-1:0] m_rvalid,
    input  logic [2**MST_WIDTH-1:0] m_rready,
    output logic [DATA_WIDTH-1:0]   m_rdata,
    output logic [ID_WIDTH-1:0]     m_rid,
    output logic [1:0]              m_rresp,
    output logic                    m_rlast,
    output logic [15:0]             err_cnt
);
    localparam int N     = 2**MST_WIDTH;
    localparam int PTR_W = $clog2(OST_DEPTH);
    localparam logic [MST_WIDTH-1:0] MST_ONE  = MST_WIDTH'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]       CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]       CNT_FULL = (PTR_W+1)'(OST_DEPTH);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state, state_nxt;
    logic [MST_WIDTH-1:0]   grant, grant_nxt, rr_ptr, pick, idx;
    logic                   found, push, pop, full, empty;
    logic [MST_WIDTH-1:0]   order_mem [OST_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]         count;
    logic [MST_WIDTH-1:0]   head;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = order_mem[rd_ptr];

    // Circular scan starting at rr_ptr; the first requester found wins.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = rr_ptr + MST_WIDTH'(i);
            if (!found && m_arvalid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (push)
                rr_ptr <= grant + MST_ONE;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        s_arvalid = 1'b0;
        m_arready = '0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (found && !full) begin
                    grant_nxt = pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                s_arvalid        = m_arvalid[grant];
                m_arready[grant] = s_arready;
                if (m_arvalid[grant] && s_arready) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_araddr = m_araddr[grant];
    assign s_arid   = m_arid[grant];
    assign s_arlen  = m_arlen[grant];

    always_ff @(posedge clk) begin
        if (push)
            order_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        m_rvalid = '0;
        if (!empty) begin
            m_rvalid[head] = s_rvalid;
            s_rready       = m_rready[head];
        end else begin
`ifdef AXI_RD_ARB_ORPHAN_DRAIN_EN
            s_rready = 1'b1;
`else
            s_rready = 1'b0;
`endif
        end
    end

    assign pop     = !empty && s_rvalid && s_rready && s_rlast;
    assign m_rdata = s_rdata;
    assign m_rid   = s_rid;
    assign m_rresp = s_rresp;
    assign m_rlast = s_rlast;

`ifdef AXI_RD_ARB_ORPHAN_DRAIN_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_cnt <= '0;
        else if (empty && s_rvalid && (err_cnt != '1))
            err_cnt <= err_cnt + 16'd1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_inter_rd_arb.sv
// Directed bench for axi_inter_rd_arb (default parameters: 4 masters, 4 outstanding bursts).
module tb_axi_inter_rd_arb;
`ifdef AXI_RD_ARB_ORPHAN_DRAIN_EN
    localparam bit DRAIN = 1'b1;
`else
    localparam bit DRAIN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  m_arvalid, m_arready;
    logic [31:0] m_araddr [4];
    logic [3:0]  m_arid   [4];
    logic [7:0]  m_arlen  [4];
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid;
    logic [7:0]  s_arlen;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [3:0]  s_rid;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [3:0]  m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [3:0]  m_rid;
    logic [1:0]  m_rresp;
    logic        m_rlast;
    logic [15:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    axi_inter_rd_arb #(
        .MST_WIDTH (2),
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ID_WIDTH  (4),
        .OST_DEPTH (4)
    ) dut (
        .clk(clk), .rstn(rstn),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_araddr(m_araddr), .m_arid(m_arid), .m_arlen(m_arlen),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rstn      = 1'b0;
        m_arvalid = '0;
        m_rready  = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rid     = '0;
        s_rresp   = '0;
        s_rlast   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_araddr[i] = 32'(i) * 32'h100;
            m_arid[i]   = 4'(i);
            m_arlen[i]  = 8'd0;
        end
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        rstn = 1'b0;
        #1;
        n_cmp++; if (s_arvalid !== 1'b0) begin n_err++; $display("FAIL reset_s_arvalid: got %b want 0", s_arvalid); end
        n_cmp++; if (m_arready !== 4'b0000) begin n_err++; $display("FAIL reset_m_arready: got %b want 0000", m_arready); end
        n_cmp++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL reset_m_rvalid: got %b want 0000", m_rvalid); end
        n_cmp++; if (s_rready !== DRAIN) begin n_err++; $display("FAIL reset_s_rready: got %b want %b", s_rready, DRAIN); end
        n_cmp++; if (err_cnt !== 16'd0) begin n_err++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        m_araddr[2] = 32'h1000;
        m_arlen[2]  = 8'd3;
        m_arid[2]   = 4'h5;
        m_arvalid   = 4'b0100;
        #1;
        n_cmp++; if (s_arvalid !== 1'b0) begin n_err++; $display("FAIL single_idle_arvalid: got %b want 0", s_arvalid); end
        tick();
        n_cmp++; if (s_arvalid !== 1'b1) begin n_err++; $display("FAIL single_arvalid: got %b want 1", s_arvalid); end
        n_cmp++; if (s_araddr !== 32'h1000) begin n_err++; $display("FAIL single_araddr: got %h want 00001000", s_araddr); end
        n_cmp++; if (s_arlen !== 8'd3 || s_arid !== 4'h5) begin n_err++; $display("FAIL single_arlen_id: got %0d/%h want 3/5", s_arlen, s_arid); end
        n_cmp++; if (m_arready !== 4'b0000) begin n_err++; $display("FAIL single_arready_stall: got %b want 0000", m_arready); end
        s_arready = 1'b1;
        #1;
        n_cmp++; if (m_arready !== 4'b0100) begin n_err++; $display("FAIL single_arready: got %b want 0100", m_arready); end
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        m_rready  = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 1'b1;
            s_rdata  = 32'hA0 + 32'(b);
            s_rid    = 4'h5;
            s_rlast  = (b == 3);
            #1;
            n_cmp++; if (m_rvalid !== 4'b0100) begin n_err++; $display("FAIL single_rvalid_b%0d: got %b want 0100", b, m_rvalid); end
            n_cmp++; if (m_rdata !== 32'hA0 + 32'(b) || m_rid !== 4'h5) begin n_err++; $display("FAIL single_rdata_b%0d: got %h/%h want %h/5", b, m_rdata, m_rid, 32'hA0 + 32'(b)); end
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        n_cmp++; if (s_rready !== DRAIN) begin n_err++; $display("FAIL single_popped: got s_rready %b want %b", s_rready, DRAIN); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        m_arvalid = 4'b1111;
        s_arready = 1'b1;
        m_rready  = 4'b1111;
        s_rlast   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            s_rvalid = (k >= 1);
            #1;
            n_cmp++; if (s_arvalid !== 1'b0) begin n_err++; $display("FAIL rr_idle_k%0d: got %b want 0", k, s_arvalid); end
            if (k >= 1) begin
                n_cmp++; if (m_rvalid !== (4'b0001 << ((k - 1) % 4))) begin n_err++; $display("FAIL rr_route_k%0d: got %b want %b", k, m_rvalid, 4'b0001 << ((k - 1) % 4)); end
            end
            tick();
            s_rvalid = 1'b0;
            #1;
            n_cmp++; if (s_arvalid !== 1'b1 || s_araddr !== 32'((k % 4) * 256)) begin n_err++; $display("FAIL rr_grant_k%0d: got %b/%h want 1/%h", k, s_arvalid, s_araddr, 32'((k % 4) * 256)); end
            tick();
        end
        m_arvalid = '0;
        s_rvalid  = 1'b1;
        #1;
        n_cmp++; if (m_rvalid !== 4'b0001) begin n_err++; $display("FAIL rr_last_route: got %b want 0001", m_rvalid); end
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    task automatic test_fifo_full();
        apply_reset();
        m_arvalid = 4'b1000;
        s_arready = 1'b1;
        m_rready  = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            n_cmp++; if (s_arvalid !== 1'b1) begin n_err++; $display("FAIL full_accept_%0d: got %b want 1", k, s_arvalid); end
            tick();
        end
        #1;
        n_cmp++; if (s_arvalid !== 1'b0) begin n_err++; $display("FAIL full_block_a: got %b want 0", s_arvalid); end
        tick();
        #1;
        n_cmp++; if (s_arvalid !== 1'b0) begin n_err++; $display("FAIL full_block_b: got %b want 0", s_arvalid); end
        tick();
        s_rvalid = 1'b1;
        s_rlast  = 1'b1;
        #1;
        n_cmp++; if (m_rvalid !== 4'b1000 || s_arvalid !== 1'b0) begin n_err++; $display("FAIL full_rlast: got rvalid %b arvalid %b want 1000/0", m_rvalid, s_arvalid); end
        tick();
        s_rvalid = 1'b0;
        #1;
        n_cmp++; if (s_arvalid !== 1'b0) begin n_err++; $display("FAIL full_after_pop: got %b want 0", s_arvalid); end
        tick();
        #1;
        n_cmp++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h300) begin n_err++; $display("FAIL full_fifth: got %b/%h want 1/00000300", s_arvalid, s_araddr); end
        tick();
        m_arvalid = '0;
        for (int j = 0; j < 4; j++) begin
            s_rvalid = 1'b1;
            #1;
            n_cmp++; if (m_rvalid !== 4'b1000) begin n_err++; $display("FAIL full_drain_%0d: got %b want 1000", j, m_rvalid); end
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        n_cmp++; if (s_rready !== DRAIN) begin n_err++; $display("FAIL full_empty: got s_rready %b want %b", s_rready, DRAIN); end
    endtask

    task automatic test_backpressure();
        logic [2:0] pat;
        pat = 3'b101;
        apply_reset();
        m_arvalid = 4'b0010;
        s_arready = 1'b1;
        tick();
        #1;
        n_cmp++; if (m_arready !== 4'b0010) begin n_err++; $display("FAIL bp_arready: got %b want 0010", m_arready); end
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = 32'hBEEF;
        for (int j = 0; j < 3; j++) begin
            m_rready = {3'b110, 1'b1} & 4'b1101 | {2'b00, pat[2 - j], 1'b0};
            s_rlast  = (j == 2);
            #1;
            n_cmp++; if (s_rready !== pat[2 - j]) begin n_err++; $display("FAIL bp_rready_%0d: got %b want %b", j, s_rready, pat[2 - j]); end
            n_cmp++; if (m_rvalid !== 4'b0010 || m_rdata !== 32'hBEEF) begin n_err++; $display("FAIL bp_route_%0d: got %b/%h want 0010/0000beef", j, m_rvalid, m_rdata); end
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        n_cmp++; if (s_rready !== DRAIN) begin n_err++; $display("FAIL bp_popped: got s_rready %b want %b", s_rready, DRAIN); end
    endtask

    task automatic test_push_pop();
        apply_reset();
        m_arvalid = 4'b0001;
        s_arready = 1'b1;
        tick();
        tick();
        m_arvalid = 4'b0100;
        tick();
        m_rready = 4'b1111;
        s_rvalid = 1'b1;
        s_rlast  = 1'b1;
        #1;
        n_cmp++; if (m_rvalid !== 4'b0001 || s_arvalid !== 1'b1) begin n_err++; $display("FAIL pp_same_cycle: got rvalid %b arvalid %b want 0001/1", m_rvalid, s_arvalid); end
        tick();
        m_arvalid = '0;
        #1;
        n_cmp++; if (m_rvalid !== 4'b0100) begin n_err++; $display("FAIL pp_next_route: got %b want 0100", m_rvalid); end
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        n_cmp++; if (s_rready !== DRAIN) begin n_err++; $display("FAIL pp_count: got s_rready %b want %b", s_rready, DRAIN); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        m_arlen[3] = 8'd3;
        m_arvalid  = 4'b1000;
        s_arready  = 1'b1;
        m_rready   = 4'b1111;
        tick();
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            s_rvalid = 1'b1;
            #1;
            n_cmp++; if (m_rvalid !== 4'b1000) begin n_err++; $display("FAIL ar_beat_%0d: got %b want 1000", b, m_rvalid); end
            tick();
        end
        m_arvalid = 4'b0001;
        #1;
        rstn = 1'b0;
        #1;
        n_cmp++; if (m_rvalid !== 4'b0000 || s_arvalid !== 1'b0 || m_arready !== 4'b0000) begin n_err++; $display("FAIL ar_cleared: got rvalid %b arvalid %b arready %b want 0000/0/0000", m_rvalid, s_arvalid, m_arready); end
        n_cmp++; if (s_rready !== DRAIN) begin n_err++; $display("FAIL ar_rready: got %b want %b", s_rready, DRAIN); end
        m_arvalid = '0;
        #1;
        rstn = 1'b1;
        tick();
        s_rlast = 1'b1;
        #1;
        n_cmp++; if (m_rvalid !== 4'b0000) begin n_err++; $display("FAIL ar_orphan_route: got %b want 0000", m_rvalid); end
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        n_cmp++; if (err_cnt !== (DRAIN ? 16'd2 : 16'd0)) begin n_err++; $display("FAIL ar_err_cnt: got %0d want %0d", err_cnt, DRAIN ? 2 : 0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fifo_full();
        test_backpressure();
        test_push_pop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_inter_rd_arb.md
Name: axi_inter_rd_arb

Overview:
- N-master to 1-slave AXI4 read-channel arbiter/return router for the interconnect, with N = 2**MST_WIDTH.
- AR side: round-robin arbitration among the master ARs, forwarding the winner to the slave.
- R side: records the grant order in an order FIFO and steers R beats back to the owning master until RLAST.
- Response-direction counterpart of the address-routing mux/demux layer; it generates its own select.

Parameters:
- MST_WIDTH, 2: log2 of master count.
- ADDR_WIDTH, 32: AR address width.
- DATA_WIDTH, 32: R data width.
- ID_WIDTH, 4: ARID/RID width.
- OST_DEPTH, 4: order FIFO depth (max outstanding bursts). Power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- m_arvalid  in  2**MST_WIDTH  per-master ARVALID.
- m_arready  out  2**MST_WIDTH  per-master ARREADY.
- m_araddr  in  [ADDR_WIDTH-1:0] x 2**MST_WIDTH (unpacked)  per-master ARADDR.
- m_arid  in  [ID_WIDTH-1:0] x 2**MST_WIDTH  per-master ARID.
- m_arlen  in  [7:0] x 2**MST_WIDTH  per-master ARLEN.
- s_arvalid  out  1  slave ARVALID.
- s_arready  in  1  slave ARREADY.
- s_araddr  out  ADDR_WIDTH  slave ARADDR.
- s_arid  out  ID_WIDTH  slave ARID.
- s_arlen  out  8  slave ARLEN.
- s_rvalid  in  1  slave RVALID.
- s_rready  out  1  slave RREADY.
- s_rdata  in  DATA_WIDTH  slave RDATA.
- s_rid  in  ID_WIDTH  slave RID.
- s_rresp  in  2  slave RRESP.
- s_rlast  in  1  slave RLAST.
- m_rvalid  out  2**MST_WIDTH  per-master RVALID.
- m_rready  in  2**MST_WIDTH  per-master RREADY.
- m_rdata  out  DATA_WIDTH  broadcast RDATA.
- m_rid  out  ID_WIDTH  broadcast RID.
- m_rresp  out  2  broadcast RRESP.
- m_rlast  out  1  broadcast RLAST.
- err_cnt  out  16  orphan-beat count (feature only).

Behaviour:
- Reset: state=IDLE, grant=0, rr_ptr=0, FIFO empty (wr/rd ptr and count 0), err_cnt=0.
- Outputs at reset: s_arvalid=0, m_arready=0, m_rvalid=0, s_rready=0.
- AR FSM, IDLE:
  - If any m_arvalid and FIFO not full: pick the first requester at or after rr_ptr (circular); register grant; go to GRANT.
  - Otherwise stay in IDLE.
  - Arbitration latency: 1 cycle from request to s_arvalid.
- AR FSM, GRANT:
  - s_arvalid = m_arvalid[grant]; s_araddr/s_arid/s_arlen = the granted master's fields.
  - m_arready[grant] = s_arready; all other m_arready = 0.
  - On s_arvalid && s_arready: push grant into FIFO, rr_ptr = grant+1 (mod N), return to IDLE.
  - Grant is held until handshake. A master deasserting ARVALID (protocol violation) keeps the grant and s_arvalid follows it low.
- Full check at grant time guarantees FIFO space, since only this path pushes. Maximum issue rate: one AR per 2 cycles.
- R path, FIFO non-empty, head = h:
  - m_rvalid[h] = s_rvalid; other bits 0.
  - s_rready = m_rready[h].
  - rdata/rid/rresp/rlast broadcast to all masters, combinational, zero latency.
  - Pop on s_rvalid && s_rready && s_rlast; the next burst's beat may route in the following cycle.
- R path, FIFO empty: s_rready=0, m_rvalid=0.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo OST_DEPTH.
- No reordering: responses must return in AR-issue order (single-ID-order slave). RID is passed through, not checked.
- Reset mid-burst: all state cleared immediately (async). Any in-flight slave beats are then orphan beats.

Optional Feature:
- Macro: AXI_RD_ARB_ORPHAN_DRAIN_EN.
- Defined, FIFO empty: s_rready=1 (orphan beats are sunk, never routed) and err_cnt increments on each s_rvalid beat, saturating at 16'hFFFF.
- Not defined: FIFO-empty behaviour as above (slave stalls); err_cnt tied to 0.

Test Plan:
- Single request: m_arvalid=4'b0100, araddr[2]=32'h1000, arlen=3 -> s_arvalid 1 cycle later with addr 32'h1000. After handshake, 4 R beats appear only on m_rvalid[2]; pop on RLAST.
- Round-robin: all 4 masters request continuously, s_arready=1 -> grant order 0,1,2,3,0, one grant every 2 cycles.
- FIFO full: OST_DEPTH=4, 4 ARs accepted, no R returned -> 5th request not granted (s_arvalid=0). After first RLAST, 5th granted next cycle.
- Back-pressure: master 1 owns head, m_rready[1] toggles 1,0,1 -> s_rready mirrors it; data held; other m_rvalid stay 0.
- Simultaneous push/pop: AR handshake in the same cycle as the RLAST of an earlier burst -> count unchanged; the next burst routes to the correct master.
- Async reset asserted during a 4-beat burst at beat 2 -> all outputs 0 immediately, FIFO empty. With AXI_RD_ARB_ORPHAN_DRAIN_EN, the 2 remaining beats are sunk and err_cnt=2.
